// File: rtl/regex_cpu.sv
// regex_cpu: single-thread execution core of the regex engine.
// Takes one (pc, cc_id) thread at a time, fetches the instruction at pc,
// executes it against the thread's character slot, then either emits zero,
// one or two successor threads or pulses accepts.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   current_characters       one character per slot, slot k at [k*CW +: CW]
//   end_of_string            per-slot end-of-input flag
//   input_pc_*               incoming thread (valid/ready)
//   memory_*                 instruction fetch (valid/ready, data one cycle later)
//   output_pc_*, output_cc_id  successor thread (valid/ready)
//   accepts                  one-cycle pulse when the thread accepts
module regex_cpu #(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
  input  logic [2**CC_ID_BITS-1:0]                      end_of_string,
  input  logic                                          input_pc_valid,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  output logic                                          input_pc_ready,
  output logic                                          memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic                                          memory_ready,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          output_pc_valid,
  output logic [PC_WIDTH-1:0]                           output_pc,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  input  logic                                          output_pc_ready,
  output logic                                          accepts
);
  localparam int NUM_SLOTS = 2**CC_ID_BITS;

  localparam logic [2:0] OP_ACCEPT         = 3'b000;
  localparam logic [2:0] OP_SPLIT          = 3'b001;
  localparam logic [2:0] OP_MATCH          = 3'b010;
  localparam logic [2:0] OP_JMP            = 3'b011;
  localparam logic [2:0] OP_END            = 3'b100;
  localparam logic [2:0] OP_MATCH_ANY      = 3'b101;
  localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'b110;
  localparam logic [2:0] OP_NOT_MATCH      = 3'b111;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, EXEC, OUT1, OUT2} state_t;

  state_t                  state;
  logic [PC_WIDTH-1:0]     pc_r;
  logic [CC_ID_BITS-1:0]   cc_r;
  logic [MEMORY_WIDTH-1:0] instr;

  // unpack the character window into per-slot entries
  logic [CHARACTER_WIDTH-1:0] chars [NUM_SLOTS];
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign chars[k] = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  end

  logic [2:0]                 op;
  logic [PC_WIDTH-1:0]        tgt;
  logic [CHARACTER_WIDTH-1:0] lit;
  logic [CHARACTER_WIDTH-1:0] ch;
  logic                       eos;
  assign op  = instr[MEMORY_WIDTH-1 -: 3];
  assign tgt = instr[PC_WIDTH-1:0];
  assign lit = instr[CHARACTER_WIDTH-1:0];
  assign ch  = chars[cc_r];
  assign eos = end_of_string[cc_r];

  assign memory_addr = MEMORY_ADDR_WIDTH'(pc_r);

  // EXEC decode: first successor (if any) and the accept decision.
  // Characters and eos are only looked at while in EXEC.
  logic                  emit, acc;
  logic [PC_WIDTH-1:0]   nxt_pc;
  logic [CC_ID_BITS-1:0] nxt_cc;
  always_comb begin
    emit   = 1'b0;
    acc    = 1'b0;
    nxt_pc = pc_r + 1'b1;
    nxt_cc = cc_r + 1'b1;
    unique case (op)
      OP_JMP:            begin emit = 1'b1; nxt_pc = tgt; nxt_cc = cc_r; end
      OP_SPLIT:          begin emit = 1'b1; nxt_cc = cc_r; end
      OP_MATCH:          emit = !eos && (ch == lit);
      OP_NOT_MATCH:      emit = !eos && (ch != lit);
      OP_MATCH_ANY:      emit = !eos;
      OP_ACCEPT:         acc  = eos;
      OP_ACCEPT_PARTIAL: acc  = 1'b1;
      OP_END:            ;
      default:           ;
    endcase
  end

  assign accepts = (state == EXEC) && acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc_r            <= '0;
      cc_r            <= '0;
      instr           <= '0;
      input_pc_ready  <= 1'b1;
      memory_valid    <= 1'b0;
      output_pc_valid <= 1'b0;
      output_pc       <= '0;
      output_cc_id    <= '0;
    end else begin
      unique case (state)
        IDLE: if (input_pc_valid) begin
          pc_r           <= input_pc;
          cc_r           <= input_cc_id;
          input_pc_ready <= 1'b0;
          memory_valid   <= 1'b1;
          state          <= FETCH;
        end
        FETCH: if (memory_ready) begin
          memory_valid <= 1'b0;
          state        <= WAIT_DATA;
        end
        WAIT_DATA: begin
          instr <= memory_data;
          state <= EXEC;
        end
        EXEC: begin
          if (emit) begin
            output_pc_valid <= 1'b1;
            output_pc       <= nxt_pc;
            output_cc_id    <= nxt_cc;
            state           <= OUT1;
          end else begin
            input_pc_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        OUT1: if (output_pc_ready) begin
          if (op == OP_SPLIT) begin
            // second SPLIT branch keeps the slot, jumps to data
            output_pc <= tgt;
            state     <= OUT2;
          end else begin
            output_pc_valid <= 1'b0;
            input_pc_ready  <= 1'b1;
            state           <= IDLE;
          end
        end
        OUT2: if (output_pc_ready) begin
          output_pc_valid <= 1'b0;
          input_pc_ready  <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          output_pc_valid <= 1'b0;
          memory_valid    <= 1'b0;
          input_pc_ready  <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regex_cpu.sv
// Scoreboard bench for regex_cpu: threads push expected successors/accepts,
// a monitor pops and compares whenever the DUT presents an output.
module tb_regex_cpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_characters;
  logic [3:0]  end_of_string;
  logic        input_pc_valid;
  logic [1:0]  input_cc_id;
  logic [8:0]  input_pc;
  logic        input_pc_ready;
  logic        memory_valid;
  logic [10:0] memory_addr;
  logic        memory_ready;
  logic [15:0] memory_data;
  logic        output_pc_valid;
  logic [8:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        output_pc_ready;
  logic        accepts;

  regex_cpu dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_cc_id(input_cc_id),
    .input_pc(input_pc), .input_pc_ready(input_pc_ready),
    .memory_valid(memory_valid), .memory_addr(memory_addr),
    .memory_ready(memory_ready), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc(output_pc),
    .output_cc_id(output_cc_id), .output_pc_ready(output_pc_ready),
    .accepts(accepts)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic acc; logic [8:0] pc; logic [1:0] cc;} exp_t;
  exp_t        q[$];
  logic [15:0] imem [0:2047];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_out(input logic [8:0] pc, input logic [1:0] cc);
    q.push_back('{acc: 1'b0, pc: pc, cc: cc});
  endtask

  task automatic exp_acc();
    q.push_back('{acc: 1'b1, pc: 9'd0, cc: 2'd0});
  endtask

  task automatic set_ch(input int k, input logic [7:0] c);
    current_characters[k*8 +: 8] = c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!input_pc_ready && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL idle_timeout: input_pc_ready still 0 after %0d cycles", n);
    end
  endtask

  // offer one thread; DUT is idle so the handshake lands on the next edge
  task automatic issue(input logic [8:0] pc, input logic [1:0] cc);
    wait_idle();
    input_pc_valid = 1'b1;
    input_pc       = pc;
    input_cc_id    = cc;
    tick();
    input_pc_valid = 1'b0;
    chk("ready_drop", input_pc_ready, 0);
  endtask

  task automatic run(input logic [8:0] pc, input logic [1:0] cc);
    issue(pc, cc);
    wait_idle();
  endtask

  // memory model: data appears the cycle after the request handshake
  initial begin
    logic        hs;
    logic [10:0] a;
    memory_data = '0;
    forever begin
      @(negedge clk);
      hs = memory_valid && memory_ready && !rst;
      a  = memory_addr;
      @(posedge clk); #1;
      if (hs) begin
        memory_data = imem[a];
        chk("mem_valid_drop", memory_valid, 0);
      end
    end
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (accepts && output_pc_valid)
          chk("accept_excl", 1, 0);
        if (accepts) begin
          if (q.size() == 0) chk("unexpected_accept", 1, 0);
          else begin e = q.pop_front(); chk("accept_kind", e.acc, 1); end
        end
        if (output_pc_valid && output_pc_ready) begin
          if (q.size() == 0) chk("unexpected_output", {21'd0, output_pc, output_cc_id}, 0);
          else begin
            e = q.pop_front();
            chk("out_kind", e.acc, 0);
            chk("out_pc", output_pc, e.pc);
            chk("out_cc", output_cc_id, e.cc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [8:0] pc, tg;
    for (int i = 0; i < 2048; i++) imem[i] = 16'h8000;
    rst = 1'b1; input_pc_valid = 0; input_pc = 0; input_cc_id = 0;
    memory_ready = 1'b1; output_pc_ready = 1'b1;
    current_characters = '0; end_of_string = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("rst_ready", input_pc_ready, 1);
    chk("rst_mvalid", memory_valid, 0);
    chk("rst_ovalid", output_pc_valid, 0);
    chk("rst_accepts", accepts, 0);

    // JMP with memory stall
    imem[5] = 16'h6062;
    memory_ready = 1'b0;
    exp_out(9'd98, 2'd2);
    issue(9'd5, 2'd2);
    chk("fetch_valid", memory_valid, 1);
    chk("fetch_addr", memory_addr, 5);
    tick(); tick();
    chk("fetch_hold", memory_valid, 1);
    chk("fetch_addr_hold", memory_addr, 5);
    memory_ready = 1'b1;
    n = 0;
    while (!output_pc_valid && n < 20) begin tick(); n++; end
    chk("jmp_valid_seen", output_pc_valid, 1);
    tick();  // handshake edge
    tick(); tick();
    chk("jmp_valid_low", output_pc_valid, 0);
    for (int i = 0; i < 10; i++) begin
      chk("post_ready", input_pc_ready, 1);
      chk("post_ovalid", output_pc_valid, 0);
      tick();
    end

    // JMP sweep
    for (int i = 0; i <= 15; i++) begin
      pc = 9'(i * 34);
      tg = 9'(98 + (i * 206) / 15);
      imem[pc] = {3'b011, 4'd0, tg};
      exp_out(tg, 2'(i % 4));
      run(pc, 2'(i % 4));
    end

    // reset while fetching aborts the thread
    memory_ready = 1'b0;
    issue(9'd20, 2'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_ready", input_pc_ready, 1);
    chk("abort_mvalid", memory_valid, 0);
    memory_ready = 1'b1;

    // SPLIT with consumer back-pressure
    imem[10] = 16'h2028;
    output_pc_ready = 1'b0;
    exp_out(9'd11, 2'd1); exp_out(9'd40, 2'd1);
    issue(9'd10, 2'd1);
    n = 0;
    while (!output_pc_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("split_hold_v", output_pc_valid, 1);
      chk("split_hold_pc", output_pc, 11);
      tick();
    end
    output_pc_ready = 1'b1;
    wait_idle();

    // MATCH / NOT_MATCH / MATCH_ANY / END
    imem[7] = 16'h4061;
    set_ch(3, 8'h61);
    exp_out(9'd8, 2'd0);
    run(9'd7, 2'd3);
    set_ch(3, 8'h62);
    run(9'd7, 2'd3);
    set_ch(3, 8'h61); end_of_string = 4'b1000;
    run(9'd7, 2'd3);
    end_of_string = '0;
    imem[12] = 16'hE078;
    set_ch(1, 8'h79);
    exp_out(9'd13, 2'd2);
    run(9'd12, 2'd1);
    set_ch(1, 8'h78);
    run(9'd12, 2'd1);
    imem[511] = 16'hA000;
    exp_out(9'd0, 2'd1);
    run(9'd511, 2'd0);
    end_of_string = 4'b0001;
    run(9'd511, 2'd0);
    end_of_string = '0;
    imem[30] = 16'h8000;
    run(9'd30, 2'd2);

    // ACCEPT / ACCEPT_PARTIAL
    imem[3] = 16'h0000;
    end_of_string = 4'b0100;
    exp_acc();
    run(9'd3, 2'd2);
    end_of_string = 4'b1011;
    run(9'd3, 2'd2);
    imem[4] = 16'hC000;
    end_of_string = '0;
    exp_acc();
    run(9'd4, 2'd1);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
